// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO of fetched instructions with flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage has no reset; an entry is only ever read after count says it was written.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: sequential prefetch into a credit-limited queue, with
// redirect flush and discard of responses still in flight.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        de_valid,
  input  logic        de_ready,
  output logic [31:0] de_inst,
  output logic [31:0] de_pc,
  output logic [31:0] de_pcinc
);

  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  logic [31:0]  fetch_pc;
  logic [31:0]  resp_pc;
  logic [31:0]  target_pc;
  cnt_t         outstanding;
  cnt_t         drop;
  cnt_t         count;
  sum_t         credit_used;
  logic         fetch_en;
  logic         xfer;
  logic         push;
  logic         pop;
  logic         empty;
  fetch_entry_t head;
  fetch_entry_t push_data;

  // fetch_en keeps imem_req low while in reset and releases it one edge later.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign imem_req    = fetch_en && !redirect && (credit_used < sum_t'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign xfer        = imem_req && imem_rdy;
  assign target_pc   = redirect_pc & ~32'h3;

  assign push      = imem_rvalid && !redirect && (drop == '0);
  assign pop       = de_valid && de_ready && !redirect;
  assign push_data = '{pc: resp_pc, inst: imem_rdata};
  assign de_valid  = !empty;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    de_inst  = NOP_INST;
    de_pc    = '0;
    de_pcinc = '0;
    if (de_valid) begin
      de_inst  = head.inst;
      de_pc    = head.pc;
      de_pcinc = head.pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_en    <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      fetch_en <= 1'b1;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc    <= target_pc;
        resp_pc     <= target_pc;
        outstanding <= outstanding - cnt_t'(imem_rvalid);
        drop        <= outstanding - cnt_t'(imem_rvalid);
      end else begin
        if (xfer) fetch_pc <= fetch_pc + 32'd4;
        if (push) resp_pc  <= resp_pc + 32'd4;
        if (imem_rvalid && (drop != '0)) drop <= drop - 1'b1;
        outstanding <= outstanding + cnt_t'(xfer) - cnt_t'(imem_rvalid);
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding != '0));
  assert property (@(posedge clk) disable iff (!rst_n) drop <= outstanding);
  assert property (@(posedge clk) disable iff (!rst_n) credit_used <= sum_t'(DEPTH));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: directed scenarios, in-order imem model,
// expected fetch addresses and decode entries checked by a separate monitor.
module tb_fetch_prefetch_queue;
  import fetch_pkg::*;

  localparam int MEM_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_rdy, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        de_valid, de_ready;
  logic [31:0] de_inst, de_pc, de_pcinc;

  logic        req2, rvalid2, valid2;
  logic [31:0] addr2, rdata2, inst2, pc2, pcinc2;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  logic [31:0] exp_addr[$];
  logic [31:0] addr2_log[$];
  int          cyc = 0;
  int          xfer_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        hold = 1'b0;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .de_valid(de_valid), .de_ready(de_ready),
    .de_inst(de_inst), .de_pc(de_pc), .de_pcinc(de_pcinc)
  );

  fetch_prefetch_queue #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(4)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req2), .imem_addr(addr2), .imem_rdy(1'b1),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .redirect(1'b0), .redirect_pc(32'h0),
    .de_valid(valid2), .de_ready(1'b0),
    .de_inst(inst2), .de_pc(pc2), .de_pcinc(pcinc2)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] p);
    exp_q.push_back('{pc: p, inst: word_of(p)});
  endtask

  // In-order imem model: accept on transfer, answer MEM_LAT cycles later unless held.
  initial begin : mem_req_side
    forever begin
      @(negedge clk);
      if (!rst_n) pend.delete();
      else if (imem_req && imem_rdy) pend.push_back('{addr: imem_addr, due: cyc + MEM_LAT});
    end
  end

  initial begin : mem_resp_side
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      imem_rvalid = 1'b0;
      if (!rst_n) pend.delete();
      else if (!hold && pend.size() != 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(pend[0].addr);
        void'(pend.pop_front());
      end
    end
  end

  initial begin : mem2_side
    logic        x2;
    logic [31:0] a2;
    x2 = 1'b0;
    a2 = '0;
    rvalid2 = 1'b0;
    rdata2  = '0;
    forever begin
      @(negedge clk);
      x2 = rst_n && req2;
      if (x2) begin
        a2 = addr2;
        addr2_log.push_back(addr2);
      end
      @(posedge clk);
      #2;
      rvalid2 = x2 && rst_n;
      rdata2  = word_of(a2);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_req && imem_rdy) begin
          xfer_cnt++;
          if (exp_addr.size() != 0) check("imem_addr", imem_addr, exp_addr.pop_front());
        end
        if (de_valid && de_ready && !redirect) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_pop: got de_pc %08h, expected no entry", de_pc);
          end else begin
            e = exp_q.pop_front();
            check("de_pc", de_pc, e.pc);
            check("de_inst", de_inst, e.inst);
            check("de_pcinc", de_pcinc, e.pc + 32'd4);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    de_ready = 1'b0;
    imem_rdy = 1'b1;
    hold = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    exp_addr.delete();
    addr2_log.delete();
    #3;
    rst_n = 1'b1;
    xfer_cnt = 0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    de_ready = 1'b0;
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    check({name, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int   n;
    logic found;
    imem_rdy = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    de_ready = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("reset_imem_req", 32'(imem_req), 32'd0);
    check("reset_de_valid", 32'(de_valid), 32'd0);
    check("reset_de_inst", de_inst, NOP_INST);
    check("reset_de_pc", de_pc, 32'd0);
    check("reset_de_pcinc", de_pcinc, 32'd0);

    // Stream: one word per cycle from pc 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(32'(i * 4));
      push_exp(32'(i * 4));
    end
    @(posedge clk);
    #1;
    de_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = de_valid;
    end
    check("stream_first_valid", 32'(found), 32'd1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (de_valid) n++;
      if (i < 7) @(negedge clk);
    end
    check("stream_rate", 32'(n), 32'd8);
    @(posedge clk);
    #1;
    de_ready = 1'b0;
    check("stream_left", 32'(exp_q.size()), 32'd0);

    // Backpressure: four transfers fill the credit, then drain in order
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_addr.push_back(32'(i * 4));
      push_exp(32'(i * 4));
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_xfers", 32'(xfer_cnt), 32'd4);
    check("bp_req_low", 32'(imem_req), 32'd0);
    check("bp_head_pc", de_pc, 32'd0);
    @(posedge clk);
    #1;
    de_ready = 1'b1;
    wait_drain("bp", 40);

    // Redirect with two requests in flight
    do_reset();
    imem_rdy = 1'b0;
    hold = 1'b1;
    exp_addr = '{32'h0, 32'h4, 32'h100, 32'h104};
    push_exp(32'h100);
    push_exp(32'h104);
    push_exp(32'h108);
    repeat (2) @(posedge clk);
    #1;
    imem_rdy = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    imem_rdy = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    check("redir_req_low", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    hold = 1'b0;
    imem_rdy = 1'b1;
    de_ready = 1'b1;
    wait_drain("redir", 40);

    // Redirect coincident with a response and a would-be pop
    do_reset();
    imem_rdy = 1'b0;
    hold = 1'b1;
    exp_addr = '{32'h0, 32'h4, 32'h40};
    push_exp(32'h40);
    push_exp(32'h44);
    repeat (2) @(posedge clk);
    #1;
    imem_rdy = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    imem_rdy = 1'b0;
    hold = 1'b0;
    @(posedge clk);
    #1;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    de_ready = 1'b1;
    @(negedge clk);
    check("coinc_pre_valid", 32'(de_valid), 32'd1);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    imem_rdy = 1'b1;
    @(negedge clk);
    check("coinc_flushed", 32'(de_valid), 32'd0);
    wait_drain("coinc", 40);

    // Misaligned redirect target is word-aligned
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    redirect = 1'b1;
    redirect_pc = 32'h203;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    de_ready = 1'b1;
    exp_addr.push_back(32'h200);
    push_exp(32'h200);
    push_exp(32'h204);
    wait_drain("misalign", 40);

    // RESET_PC at the top of the address space wraps to 0
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = valid2;
    end
    check("wrap_found", 32'(found), 32'd1);
    check("wrap_de_pc", pc2, 32'hFFFF_FFFC);
    check("wrap_de_pcinc", pcinc2, 32'd0);
    check("wrap_de_inst", inst2, word_of(32'hFFFF_FFFC));
    check("wrap_addr1", (addr2_log.size() >= 2) ? addr2_log[1] : 32'hDEAD_BEEF, 32'd0);

    // Asynchronous reset mid-burst: two queued, two in flight
    do_reset();
    hold = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    hold = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    hold = 1'b1;
    @(negedge clk);
    check("async_pre_valid", 32'(de_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_imem_req", 32'(imem_req), 32'd0);
    check("async_de_valid", 32'(de_valid), 32'd0);
    check("async_de_inst", de_inst, NOP_INST);
    check("async_de_pc", de_pc, 32'd0);
    check("async_de_pcinc", de_pcinc, 32'd0);
    repeat (2) @(posedge clk);
    exp_q.delete();
    exp_addr.delete();
    #3;
    rst_n = 1'b1;
    hold = 1'b0;
    exp_addr.push_back(32'h0);
    push_exp(32'h0);
    push_exp(32'h4);
    @(posedge clk);
    #1;
    de_ready = 1'b1;
    wait_drain("async", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
